convert_values_control: RTL and testbench

Sequencing controller for the value-conversion datapath. It walks the datapath through its stages for each circuit element: reset, choose element, int-to-float conversion, exponent multiply, resistor inversion, and float-register write. It drives the datapath's `go_*` / `ld_memory` request levels and consumes its done handshakes. It also counts converted elements, reports completion to the top-level solver FSM, and guards every stage with a watchdog.

---
 rtl/convert_values_pkg.sv | 65 ++++++
 rtl/convert_values_control_if.sv | 56 +++++
 rtl/convert_values_control_stage_watchdog.sv | 46 ++++
 rtl/convert_values_control.sv | 160 ++++++++++++++++
 tb/tb_convert_values_control.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/convert_values_pkg.sv
`default_nettype none
// ============================================================================
// Module   : convert_values_pkg
// Purpose  : Shared types and constants for the value-conversion controller
//            and its datapath. Holds the controller state encoding, the
//            err_stage codes and the IEEE-754 single constants used by the
//            datapath.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package convert_values_pkg;

    // Controller states, in sequencing order.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RESET   = 4'd1,
        ST_CHOOSE  = 4'd2,
        ST_CONVERT = 4'd3,
        ST_MULT    = 4'd4,
        ST_INVERT  = 4'd5,
        ST_LOAD    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERROR   = 4'd8
    } state_t;

    // err_stage encodings reported when a stage's watchdog expires.
    localparam logic [2:0] ERR_RESET   = 3'd0;
    localparam logic [2:0] ERR_CHOOSE  = 3'd1;
    localparam logic [2:0] ERR_CONVERT = 3'd2;
    localparam logic [2:0] ERR_MULT    = 3'd3;
    localparam logic [2:0] ERR_INVERT  = 3'd4;
    localparam logic [2:0] ERR_LOAD    = 3'd5;

    // Element counter width and its saturation value.
    localparam int         ELEM_W   = 5;
    localparam logic [4:0] ELEM_MAX = 5'd31;

    // Floating-point constants shared with the datapath.
    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] TEN   = 32'h4120_0000;
    localparam logic [31:0] TENTH = 32'h3DCC_CCCD;

    // True for the stages that wait on a datapath handshake.
    function automatic logic is_stage(input state_t s);
        return (s == ST_RESET)   || (s == ST_CHOOSE) || (s == ST_CONVERT) ||
               (s == ST_MULT)    || (s == ST_INVERT) || (s == ST_LOAD);
    endfunction

    // Maps a waiting stage to its err_stage code.
    function automatic logic [2:0] stage_code(input state_t s);
        logic [2:0] code;
        code = ERR_RESET;
        case (s)
            ST_CHOOSE:  code = ERR_CHOOSE;
            ST_CONVERT: code = ERR_CONVERT;
            ST_MULT:    code = ERR_MULT;
            ST_INVERT:  code = ERR_INVERT;
            ST_LOAD:    code = ERR_LOAD;
            default:    code = ERR_RESET;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/convert_values_control_if.sv
`default_nettype none
// ============================================================================
// Module   : convert_values_control_if
// Purpose  : Bundles the controller's command, handshake and status signals.
//            master : controller side (drives requests and status)
//            slave  : datapath / solver side (drives start, abort, dones)
// Signals  : start, abort, seven done handshakes, six stage requests,
//            busy, done, error, err_stage[2:0], elements_converted[4:0]
// Revision : 1.0 - initial release
// ============================================================================
interface convert_values_control_if;
    import convert_values_pkg::*;

    logic              start;
    logic              abort;
    logic              data_reset_done;
    logic              element_chosen;
    logic              fp_conversion_done;
    logic              exponent_multiplied;
    logic              resistor_inversion_done;
    logic              memory_loaded;
    logic              all_done;
    logic              go_reset_data;
    logic              go_choose_element;
    logic              go_convert_fp;
    logic              go_multiply_exp;
    logic              go_invert_resistor;
    logic              ld_memory;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        err_stage;
    logic [ELEM_W-1:0] elements_converted;

    modport master (
        input  start, abort,
               data_reset_done, element_chosen, fp_conversion_done,
               exponent_multiplied, resistor_inversion_done, memory_loaded,
               all_done,
        output go_reset_data, go_choose_element, go_convert_fp,
               go_multiply_exp, go_invert_resistor, ld_memory,
               busy, done, error, err_stage, elements_converted
    );

    modport slave (
        output start, abort,
               data_reset_done, element_chosen, fp_conversion_done,
               exponent_multiplied, resistor_inversion_done, memory_loaded,
               all_done,
        input  go_reset_data, go_choose_element, go_convert_fp,
               go_multiply_exp, go_invert_resistor, ld_memory,
               busy, done, error, err_stage, elements_converted
    );

endinterface
`default_nettype wire

// File: rtl/convert_values_control_stage_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : stage_watchdog
// Purpose  : Per-stage cycle counter. Cleared on every controller state
//            change, counts while enabled, and flags expiry once the count
//            reaches TIMEOUT. The count holds at TIMEOUT so it never wraps.
// Ports    : clk, resetn (async, active-low), clear, enable -> expired
// Revision : 1.0 - initial release
// ============================================================================
module stage_watchdog #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/convert_values_control.sv
`default_nettype none
// ============================================================================
// Module   : convert_values_control
// Purpose  : Sequences the value-conversion datapath through reset, element
//            choice, int-to-float, exponent multiply, resistor inversion and
//            float-register write for each element. Counts converted
//            elements, reports completion and guards each stage with a
//            watchdog.
// Ports    : clk, resetn (async, active-low)
//            bus (convert_values_control_if.master): start/abort, done
//            handshakes in; stage requests, busy/done/error, err_stage,
//            elements_converted out
// Revision : 1.0 - initial release
// ============================================================================
module convert_values_control
    import convert_values_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    convert_values_control_if.master   bus
);

    state_t            state_q;
    state_t            state_d;
    logic [ELEM_W-1:0] elem_q;
    logic [ELEM_W-1:0] elem_d;
    logic [2:0]        err_q;
    logic [2:0]        err_d;
    logic              wd_expired;
    logic              wd_clear;
    logic              wd_enable;

    // ------------------------------------------------------------------
    // Next state. abort overrides everything; within a stage the done
    // handshake is checked before the watchdog so a done arriving on the
    // expiry edge still advances.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (bus.data_reset_done) state_d = ST_CHOOSE;
                    else if (wd_expired)     state_d = ST_ERROR;
                end
                ST_CHOOSE: begin
                    if (bus.all_done)            state_d = ST_DONE;
                    else if (bus.element_chosen) state_d = ST_CONVERT;
                    else if (wd_expired)         state_d = ST_ERROR;
                end
                ST_CONVERT: begin
                    if (bus.fp_conversion_done) state_d = ST_MULT;
                    else if (wd_expired)        state_d = ST_ERROR;
                end
                ST_MULT: begin
                    if (bus.exponent_multiplied) state_d = ST_INVERT;
                    else if (wd_expired)         state_d = ST_ERROR;
                end
                ST_INVERT: begin
                    if (bus.resistor_inversion_done) state_d = ST_LOAD;
                    else if (wd_expired)             state_d = ST_ERROR;
                end
                ST_LOAD: begin
                    if (bus.memory_loaded) state_d = ST_CHOOSE;
                    else if (wd_expired)   state_d = ST_ERROR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Element counter and err_stage capture.
    // ------------------------------------------------------------------
    always_comb begin
        elem_d = elem_q;
        err_d  = err_q;

        if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
            // A new run begins: forget the previous run's results.
            elem_d = '0;
            err_d  = '0;
        end else if ((state_q == ST_LOAD) && (state_d == ST_CHOOSE) &&
                     (elem_q != ELEM_MAX)) begin
            elem_d = elem_q + 1'b1;
        end

        if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
            err_d = stage_code(state_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            elem_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: restarts on each state change, runs only in waiting stages.
    // ------------------------------------------------------------------
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = is_stage(state_q);

    stage_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // ------------------------------------------------------------------
    // Moore outputs decoded from the registered state.
    // ------------------------------------------------------------------
    always_comb begin
        bus.go_reset_data      = 1'b0;
        bus.go_choose_element  = 1'b0;
        bus.go_convert_fp      = 1'b0;
        bus.go_multiply_exp    = 1'b0;
        bus.go_invert_resistor = 1'b0;
        bus.ld_memory          = 1'b0;
        bus.done               = 1'b0;
        bus.error              = 1'b0;
        case (state_q)
            ST_RESET:   bus.go_reset_data      = 1'b1;
            ST_CHOOSE:  bus.go_choose_element  = 1'b1;
            ST_CONVERT: bus.go_convert_fp      = 1'b1;
            ST_MULT:    bus.go_multiply_exp    = 1'b1;
            ST_INVERT:  bus.go_invert_resistor = 1'b1;
            ST_LOAD:    bus.ld_memory          = 1'b1;
            ST_DONE:    bus.done               = 1'b1;
            ST_ERROR:   bus.error              = 1'b1;
            default:    ;
        endcase
    end

    assign bus.busy               = is_stage(state_q);
    assign bus.err_stage          = err_q;
    assign bus.elements_converted = elem_q;

endmodule
`default_nettype wire

// File: tb/tb_convert_values_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_convert_values_control
// Purpose  : Self-checking bench for convert_values_control. A behavioural
//            datapath answers each request after a (random or fixed)
//            latency; the expected request order, stage occupancy and final
//            counts are derived from the number of elements in the run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_convert_values_control;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    // run modes
    localparam int M_NORMAL = 0;  // answer every request
    localparam int M_STALL  = 1;  // never answer tgt stage (after tgt_elem loads)
    localparam int M_STOP   = 2;  // return on entry to tgt stage (after tgt_elem loads)
    localparam int M_LONG   = 3;  // answer tgt stage exactly on the watchdog edge

    // run end reasons
    localparam int R_BUDGET = 0;
    localparam int R_DONE   = 1;
    localparam int R_ERROR  = 2;
    localparam int R_STOP   = 3;

    logic clk;
    logic resetn;

    convert_values_control_if bus ();

    convert_values_control #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    int trace[$];
    int exp_cycles;
    int busy_cycles;
    int entry_cycle;
    int err_cycle;
    int onehot_bad;
    int reason;

    // Index of the single active request: 0..5, 6 = none, 7 = several.
    function automatic int req_idx();
        logic [5:0] v;
        int         cnt;
        int         idx;
        v = {bus.ld_memory, bus.go_invert_resistor, bus.go_multiply_exp,
             bus.go_convert_fp, bus.go_choose_element, bus.go_reset_data};
        cnt = 0;
        idx = 6;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) begin
                cnt++;
                idx = i;
            end
        end
        return (cnt > 1) ? 7 : idx;
    endfunction

    // Number of positions where the recorded trace departs from the order
    // RESET, then CHOOSE..LOAD once per element, then a final CHOOSE.
    function automatic int trace_errors(input int n);
        int exp_q[$];
        int bad;
        exp_q.push_back(0);
        for (int e = 0; e < n; e++) begin
            for (int s = 1; s <= 5; s++) exp_q.push_back(s);
        end
        exp_q.push_back(1);
        bad = (exp_q.size() > trace.size()) ? exp_q.size() - trace.size()
                                            : trace.size() - exp_q.size();
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++) begin
            if (exp_q[i] != trace[i]) bad++;
        end
        return bad;
    endfunction

    function automatic int count_in_trace(input int s);
        int c;
        c = 0;
        foreach (trace[i]) if (trace[i] == s) c++;
        return c;
    endfunction

    task automatic clear_dones();
        bus.data_reset_done         = 1'b0;
        bus.element_chosen          = 1'b0;
        bus.fp_conversion_done      = 1'b0;
        bus.exponent_multiplied     = 1'b0;
        bus.resistor_inversion_done = 1'b0;
        bus.memory_loaded           = 1'b0;
        bus.all_done                = 1'b0;
    endtask

    // Behavioural datapath: pulses start, then each cycle (at negedge)
    // answers the active request once it has been high for its latency.
    task automatic run_dp(input int n, input int lat_fix, input int mode,
                          input int tgt, input int tgt_elem, input int budget);
        int remaining;
        int loads;
        int prev;
        int age;
        int lat;
        int r;
        bit stall;
        trace.delete();
        exp_cycles  = 0;
        busy_cycles = 0;
        entry_cycle = -1;
        err_cycle   = -1;
        onehot_bad  = 0;
        reason      = R_BUDGET;
        remaining   = n;
        loads       = 0;
        prev        = -1;
        age         = 0;
        lat         = 1;
        stall       = 1'b0;
        clear_dones();
        bus.start = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            r = req_idx();
            if (r == 7) onehot_bad++;
            if (bus.busy !== (r < 6)) onehot_bad++;
            if (bus.done === 1'b1 || bus.error === 1'b1) begin
                reason = bus.done ? R_DONE : R_ERROR;
                if (bus.error === 1'b1) err_cycle = cyc;
                clear_dones();
                return;
            end
            if (r != prev) begin
                clear_dones();
                age = 0;
                if (r < 6) begin
                    trace.push_back(r);
                    lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
                    if (mode == M_LONG && r == tgt) lat = TIMEOUT + 1;
                    stall = (mode == M_STALL && r == tgt && loads >= tgt_elem);
                    if (stall) entry_cycle = cyc;
                    if (mode == M_STOP && r == tgt && loads >= tgt_elem) begin
                        reason = R_STOP;
                        return;
                    end
                    if (!stall) exp_cycles += lat;
                end
            end else begin
                age++;
            end
            if (r < 6) busy_cycles++;
            if (r < 6 && !stall && age == lat - 1) begin
                case (r)
                    0: bus.data_reset_done = 1'b1;
                    1: if (remaining == 0) bus.all_done = 1'b1;
                       else                bus.element_chosen = 1'b1;
                    2: bus.fp_conversion_done = 1'b1;
                    3: bus.exponent_multiplied = 1'b1;
                    4: bus.resistor_inversion_done = 1'b1;
                    5: begin
                        bus.memory_loaded = 1'b1;
                        loads++;
                        remaining--;
                    end
                    default: ;
                endcase
            end
            prev = r;
        end
        clear_dones();
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        clear_dones();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_idx() !== 6) begin
            miscompares++;
            $display("FAIL reset_requests: got idx %0d, want 6 (none)", req_idx());
        end
        vectors++;
        if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status: got busy/done/error %b, want 000",
                     {bus.busy, bus.done, bus.error});
        end
        vectors++;
        if (bus.err_stage !== 3'd0 || bus.elements_converted !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_counts: got err_stage %0d elems %0d, want 0 0",
                     bus.err_stage, bus.elements_converted);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || req_idx() !== 6) begin
            miscompares++;
            $display("FAIL reset_idle: got busy %b idx %0d, want 0 6", bus.busy, req_idx());
        end
    endtask

    task automatic check_run(input string name, input int n, input int exp_elems);
        vectors++;
        if (reason !== R_DONE) begin
            miscompares++;
            $display("FAIL %s_end: got reason %0d, want %0d (done)", name, reason, R_DONE);
        end
        vectors++;
        if (bus.elements_converted !== 5'(exp_elems)) begin
            miscompares++;
            $display("FAIL %s_elems: got %0d, want %0d", name, bus.elements_converted, exp_elems);
        end
        vectors++;
        if (trace_errors(n) !== 0) begin
            miscompares++;
            $display("FAIL %s_order: got %0d misplaced requests (len %0d), want 0",
                     name, trace_errors(n), trace.size());
        end
        vectors++;
        if (busy_cycles !== exp_cycles) begin
            miscompares++;
            $display("FAIL %s_cycles: got %0d busy cycles, want %0d", name, busy_cycles, exp_cycles);
        end
        vectors++;
        if (onehot_bad !== 0) begin
            miscompares++;
            $display("FAIL %s_onehot: got %0d bad cycles, want 0", name, onehot_bad);
        end
    endtask

    task automatic test_happy_path();
        run_dp(3, 2, M_NORMAL, 0, 0, 500);
        check_run("happy", 3, 3);
        vectors++;
        if (count_in_trace(2) !== 3) begin
            miscompares++;
            $display("FAIL happy_converts: got %0d, want 3", count_in_trace(2));
        end
    endtask

    task automatic test_zero_elements();
        run_dp(0, 0, M_NORMAL, 0, 0, 500);
        check_run("zero", 0, 0);
        vectors++;
        if (count_in_trace(2) !== 0) begin
            miscompares++;
            $display("FAIL zero_convert_rose: got %0d, want 0", count_in_trace(2));
        end
    endtask

    task automatic test_random_runs();
        int n;
        for (int k = 0; k < 5; k++) begin
            n = int'($urandom_range(0, 6));
            run_dp(n, 0, M_NORMAL, 0, 0, 1000);
            check_run("random", n, n);
        end
    endtask

    task automatic test_saturation();
        run_dp(33, 1, M_NORMAL, 0, 0, 2000);
        check_run("saturate", 33, 31);
    endtask

    task automatic test_timeout();
        run_dp(2, 0, M_STALL, 3, 1, 500);
        vectors++;
        if (reason !== R_ERROR || bus.err_stage !== 3'd3) begin
            miscompares++;
            $display("FAIL timeout_err: got reason %0d err_stage %0d, want %0d 3",
                     reason, bus.err_stage, R_ERROR);
        end
        vectors++;
        if (err_cycle - entry_cycle !== TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout_edges: got %0d, want %0d", err_cycle - entry_cycle, TIMEOUT + 1);
        end
        vectors++;
        if (bus.elements_converted !== 5'd1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_state: got elems %0d busy %b, want 1 0",
                     bus.elements_converted, bus.busy);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.go_reset_data !== 1'b1 || bus.error !== 1'b0 || bus.elements_converted !== 5'd0) begin
            miscompares++;
            $display("FAIL timeout_restart: got go_reset %b error %b elems %0d, want 1 0 0",
                     bus.go_reset_data, bus.error, bus.elements_converted);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic test_race();
        run_dp(1, 0, M_LONG, 2, 0, 500);
        check_run("race", 1, 1);
    endtask

    task automatic test_abort_start();
        run_dp(3, 0, M_STOP, 4, 1, 500);
        vectors++;
        if (reason !== R_STOP || bus.go_invert_resistor !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: got reason %0d invert %b, want %0d 1",
                     reason, bus.go_invert_resistor, R_STOP);
        end
        // start while busy must be ignored
        bus.start = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.go_invert_resistor !== 1'b1 || req_idx() !== 4) begin
            miscompares++;
            $display("FAIL start_busy: got idx %0d, want 4", req_idx());
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        vectors++;
        if (req_idx() !== 6 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got idx %0d busy %b done %b error %b, want 6 0 0 0",
                     req_idx(), bus.busy, bus.done, bus.error);
        end
        vectors++;
        if (bus.elements_converted !== 5'd1) begin
            miscompares++;
            $display("FAIL abort_elems: got %0d, want 1", bus.elements_converted);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        run_dp(3, 0, M_STOP, 5, 1, 500);
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if (req_idx() !== 6 || {bus.busy, bus.done, bus.error} !== 3'b000 ||
            bus.err_stage !== 3'd0 || bus.elements_converted !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset: got idx %0d status %b err %0d elems %0d, want 6 000 0 0",
                     req_idx(), {bus.busy, bus.done, bus.error}, bus.err_stage,
                     bus.elements_converted);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (req_idx() !== 6 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_release_idle: got idx %0d busy %b, want 6 0", req_idx(), bus.busy);
        end
        run_dp(2, 0, M_NORMAL, 0, 0, 500);
        check_run("after_reset", 2, 2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_happy_path();
        test_zero_elements();
        test_random_runs();
        test_saturation();
        test_timeout();
        test_race();
        test_abort_start();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global safety net so the bench always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
